d_mem_sized: RTL and testbench

- Next-generation data memory for the single-cycle/multicycle datapath, replacing the asynchronous word-only store.
- Byte-addressed, clocked, parametrised in depth. Supports byte/half/word loads and stores, with sign- or zero-extension.
- Flags misaligned, out-of-range and conflicting accesses.
- After reset, a hardware sweep clears the array before the first access is accepted.

---
 rtl/d_mem_sized.sv | 177 +++++++++++++++++
 tb/tb_d_mem_sized.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_mem_sized.sv
// Byte-addressed data memory: byte/half/word loads and stores with sign/zero extension and fault flags.
// Latency: stores commit on the accept edge; load data and fault pulses appear one cycle after accept.
// Backpressure: Ready is low during the post-reset clear sweep; otherwise one request is accepted per cycle.
//
// Ports: clk/rst_n (async active-low); Address, WriteData, MemWrite, MemRead, Size, Unsigned in;
//        ReadData, ReadValid, Ready, Error out.
// Optional build macro D_MEM_TRISTATE_EN: ReadData floats (32'hzzzz_zzzz) whenever ReadValid is low.
module d_mem_sized #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 32,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           WriteData,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    output logic [31:0]           ReadData,
    output logic                  ReadValid,
    output logic                  Ready,
    output logic                  Error
);

    localparam int IW = $clog2(DEPTH);
    // One bit wider than the address so 4*DEPTH is representable even when it equals 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(4 * DEPTH);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          rvld_q, rvld_d;
    logic [31:0]   rdat_q, rdat_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [DEPTH];

    logic          accept;
    logic          fault;
    logic [IW-1:0] idx;
    logic [1:0]    off;
    logic [31:0]   word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_val;

    logic          mem_we;
    logic [IW-1:0] mem_idx;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdat;

    assign idx    = Address[IW+1:2];
    assign off    = Address[1:0];
    assign word   = mem_q[idx];
    assign Ready  = (state_q == ST_RUN);
    assign accept = Ready && (MemRead || MemWrite);

    // Fault sources are OR-ed: priority only matters for diagnosis, and all of them yield the same pulse.
    always_comb begin
        fault = 1'b0;
        if (MemRead && MemWrite)                     fault = 1'b1;
        if (Size == 2'b11)                           fault = 1'b1;
        if ({1'b0, Address} >= ADDR_LIMIT)           fault = 1'b1;
        if (Size == 2'b01 && off[0])                 fault = 1'b1;
        if (Size == 2'b10 && off != 2'b00)           fault = 1'b1;
    end

    // Little-endian lane extraction; misaligned cases never reach here because they fault.
    always_comb begin
        ld_byte = word[7:0];
        case (off)
            2'd1:    ld_byte = word[15:8];
            2'd2:    ld_byte = word[23:16];
            2'd3:    ld_byte = word[31:24];
            default: ld_byte = word[7:0];
        endcase
        ld_half = off[1] ? word[31:16] : word[15:0];
        ld_val  = word;
        if (Size == 2'b00)
            ld_val = Unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        else if (Size == 2'b01)
            ld_val = Unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rvld_d   = 1'b0;
        rdat_d   = 32'h0;
        err_d    = 1'b0;
        mem_we   = 1'b0;
        mem_idx  = idx;
        mem_be   = 4'h0;
        mem_wdat = 32'h0;
        case (state_q)
            ST_INIT: begin
                if (INIT_CLEAR != 0) begin
                    mem_we  = 1'b1;
                    mem_idx = cnt_q;
                    mem_be  = 4'hF;
                    cnt_d   = cnt_q + IW'(1);
                    if (cnt_q == IW'(DEPTH - 1))
                        state_d = ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (accept) begin
                    if (fault) begin
                        err_d = 1'b1;
                    end else if (MemWrite) begin
                        mem_we = 1'b1;
                        case (Size)
                            2'b00: begin
                                mem_be   = 4'b0001 << off;
                                mem_wdat = {4{WriteData[7:0]}};
                            end
                            2'b01: begin
                                mem_be   = off[1] ? 4'b1100 : 4'b0011;
                                mem_wdat = {2{WriteData[15:0]}};
                            end
                            default: begin
                                mem_be   = 4'hF;
                                mem_wdat = WriteData;
                            end
                        endcase
                    end else begin
                        rvld_d = 1'b1;
                        rdat_d = ld_val;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            rvld_q  <= 1'b0;
            rdat_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rvld_q  <= rvld_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
        end
    end

    // The array itself has no reset; the INIT sweep provides the cleared contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b])
                    mem_q[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
            end
        end
    end

    assign ReadValid = rvld_q;
    assign Error     = err_q;

`ifdef D_MEM_TRISTATE_EN
    assign ReadData = rvld_q ? rdat_q : 32'hzzzz_zzzz;
`else
    // rdat_q is already forced to zero on every cycle without a load result.
    assign ReadData = rdat_q;
`endif

endmodule

// File: tb/tb_d_mem_sized.sv
module tb_d_mem_sized;

    localparam int DEPTH = 16;
`ifdef D_MEM_TRISTATE_EN
    localparam logic [31:0] IDLE_DAT = 32'hzzzz_zzzz;
`else
    localparam logic [31:0] IDLE_DAT = 32'h0000_0000;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic        Ready;
    logic        Error;

    d_mem_sized #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .INIT_CLEAR(1)) dut (
        .clk(clk), .rst_n(rst_n), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .Size(Size), .Unsigned(Unsigned),
        .ReadData(ReadData), .ReadValid(ReadValid), .Ready(Ready), .Error(Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] addr;
        logic [31:0] wd;
    } req_t;

    typedef struct {
        logic        vld;
        logic        err;
        logic [31:0] dat;
    } exp_t;

    logic [7:0] ref_mem [0:4*DEPTH-1];
    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;

    function automatic req_t mk(logic rd, logic wr, logic [1:0] sz, logic un,
                                logic [31:0] addr, logic [31:0] wd);
        req_t r;
        r.rd = rd; r.wr = wr; r.sz = sz; r.un = un; r.addr = addr; r.wd = wd;
        return r;
    endfunction

    task automatic clear_ref();
        for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
    endtask

    // Drives one request for the next edge and pushes the byte-array model's expected outcome.
    task automatic drive(input req_t r);
        exp_t        e;
        logic        flt;
        logic [31:0] a;
        logic [7:0]  b;
        logic [15:0] h;
        MemRead = r.rd; MemWrite = r.wr; Size = r.sz; Unsigned = r.un;
        Address = r.addr; WriteData = r.wd;
        a = r.addr;
        flt = (r.rd && r.wr) || (r.sz == 2'd3) || (a >= 32'(4*DEPTH)) ||
              (r.sz == 2'd1 && a[0]) || (r.sz == 2'd2 && a[1:0] != 2'b00);
        e.vld = 1'b0; e.err = 1'b0; e.dat = IDLE_DAT;
        if (r.rd || r.wr) begin
            if (flt) begin
                e.err = 1'b1;
            end else if (r.wr) begin
                ref_mem[a] = r.wd[7:0];
                if (r.sz != 2'd0) ref_mem[a+1] = r.wd[15:8];
                if (r.sz == 2'd2) begin
                    ref_mem[a+2] = r.wd[23:16];
                    ref_mem[a+3] = r.wd[31:24];
                end
            end else begin
                e.vld = 1'b1;
                b = ref_mem[a];
                h = {ref_mem[a+1], ref_mem[a]};
                if (r.sz == 2'd0)
                    e.dat = r.un ? {24'h0, b} : {{24{b[7]}}, b};
                else if (r.sz == 2'd1)
                    e.dat = r.un ? {16'h0, h} : {{16{h[15]}}, h};
                else
                    e.dat = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
            end
        end
        sb.push_back(e);
    endtask

    task automatic idle();
        MemRead = 1'b0; MemWrite = 1'b0; Size = 2'd0; Unsigned = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        int bad;
        exp_t e;
        MemRead = 1'b1; MemWrite = 1'b1; Size = 2'd3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (Ready !== 1'b0 || ReadValid !== 1'b0 || Error !== 1'b0 || ReadData !== IDLE_DAT) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b err=%b dat=%h, want 0 0 0 %h",
                     Ready, ReadValid, Error, ReadData, IDLE_DAT);
        end
        rst_n = 1'b1;
        n = 0; bad = 0;
        while (Ready !== 1'b1 && n < 100) begin
            if (ReadValid !== 1'b0 || Error !== 1'b0 || ReadData !== IDLE_DAT) bad++;
            n++;
            @(posedge clk);
            #1;
        end
        idle();
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL init_length: ready low for %0d cycles, want %0d", n, DEPTH);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL init_ignore: %0d cycles with output activity, want 0", bad);
        end
        clear_ref();
        drive(mk(1, 0, 2'd2, 0, 32'h3C, 0));
        @(posedge clk); #1; idle();
        e = sb.pop_front(); checks++;
        if (ReadValid !== e.vld || Error !== e.err || ReadData !== e.dat) begin
            errors++;
            $display("FAIL lw_after_clear: vld=%b err=%b dat=%h, want vld=%b err=%b dat=%h",
                     ReadValid, Error, ReadData, e.vld, e.err, e.dat);
        end
    endtask

    task automatic test_sized_loads();
        req_t rq[$];
        exp_t e;
        rq.push_back(mk(0, 1, 2'd2, 0, 32'h8, 32'hDEADBEEF));
        rq.push_back(mk(1, 0, 2'd0, 0, 32'h9, 0));
        rq.push_back(mk(1, 0, 2'd0, 1, 32'hB, 0));
        rq.push_back(mk(1, 0, 2'd1, 0, 32'hA, 0));
        rq.push_back(mk(1, 0, 2'd1, 1, 32'h8, 0));
        rq.push_back(mk(1, 0, 2'd2, 1, 32'h8, 0));
        foreach (rq[i]) begin
            drive(rq[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (ReadValid !== e.vld || Error !== e.err || ReadData !== e.dat) begin
                errors++;
                $display("FAIL sized[%0d]: vld=%b err=%b dat=%h, want vld=%b err=%b dat=%h",
                         i, ReadValid, Error, ReadData, e.vld, e.err, e.dat);
            end
        end
        idle();
    endtask

    task automatic test_partial_stores();
        req_t rq[$];
        exp_t e;
        rq.push_back(mk(0, 1, 2'd2, 0, 32'h4, 32'h11223344));
        rq.push_back(mk(0, 1, 2'd0, 0, 32'h6, 32'h000000AA));
        rq.push_back(mk(1, 0, 2'd2, 0, 32'h4, 0));
        rq.push_back(mk(0, 1, 2'd1, 0, 32'h4, 32'hFFFF5566));
        rq.push_back(mk(1, 0, 2'd2, 0, 32'h4, 0));
        rq.push_back(mk(0, 1, 2'd1, 0, 32'h6, 32'h00009988));
        rq.push_back(mk(1, 0, 2'd2, 0, 32'h4, 0));
        foreach (rq[i]) begin
            drive(rq[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (ReadValid !== e.vld || Error !== e.err || ReadData !== e.dat) begin
                errors++;
                $display("FAIL partial[%0d]: vld=%b err=%b dat=%h, want vld=%b err=%b dat=%h",
                         i, ReadValid, Error, ReadData, e.vld, e.err, e.dat);
            end
        end
        idle();
    endtask

    task automatic test_faults();
        req_t rq[$];
        exp_t e;
        rq.push_back(mk(1, 0, 2'd2, 0, 32'h2, 0));
        rq.push_back(mk(0, 1, 2'd1, 0, 32'h1, 32'h0000CAFE));
        rq.push_back(mk(1, 0, 2'd3, 0, 32'h4, 0));
        rq.push_back(mk(1, 1, 2'd2, 0, 32'h4, 32'h12345678));
        rq.push_back(mk(1, 0, 2'd2, 0, 32'(4*DEPTH), 0));
        rq.push_back(mk(0, 1, 2'd2, 0, 32'h5, 32'h87654321));
        rq.push_back(mk(0, 1, 2'd0, 0, 32'h8000_0004, 32'h000000EE));
        rq.push_back(mk(1, 0, 2'd2, 0, 32'h0, 0));
        rq.push_back(mk(1, 0, 2'd2, 0, 32'h4, 0));
        foreach (rq[i]) begin
            drive(rq[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (ReadValid !== e.vld || Error !== e.err || ReadData !== e.dat) begin
                errors++;
                $display("FAIL fault[%0d]: vld=%b err=%b dat=%h, want vld=%b err=%b dat=%h",
                         i, ReadValid, Error, ReadData, e.vld, e.err, e.dat);
            end
        end
        idle();
        @(posedge clk); #1;
        checks++;
        if (Error !== 1'b0 || ReadValid !== 1'b0 || ReadData !== IDLE_DAT) begin
            errors++;
            $display("FAIL idle_after_fault: err=%b vld=%b dat=%h, want 0 0 %h",
                     Error, ReadValid, ReadData, IDLE_DAT);
        end
    endtask

    task automatic test_back_to_back();
        req_t rq[$];
        exp_t e;
        int   vld_run;
        rq.push_back(mk(1, 0, 2'd2, 0, 32'h0, 0));
        rq.push_back(mk(1, 0, 2'd2, 0, 32'h4, 0));
        rq.push_back(mk(1, 0, 2'd2, 0, 32'h8, 0));
        rq.push_back(mk(0, 1, 2'd2, 0, 32'h30, 32'hA5A5_0F0F));
        rq.push_back(mk(1, 0, 2'd2, 0, 32'h30, 0));
        rq.push_back(mk(0, 1, 2'd0, 0, 32'h33, 32'h0000007E));
        rq.push_back(mk(1, 0, 2'd0, 0, 32'h33, 0));
        vld_run = 0;
        foreach (rq[i]) begin
            drive(rq[i]);
            @(posedge clk); #1;
            if (i < 3 && ReadValid === 1'b1) vld_run++;
            e = sb.pop_front(); checks++;
            if (ReadValid !== e.vld || Error !== e.err || ReadData !== e.dat) begin
                errors++;
                $display("FAIL b2b[%0d]: vld=%b err=%b dat=%h, want vld=%b err=%b dat=%h",
                         i, ReadValid, Error, ReadData, e.vld, e.err, e.dat);
            end
        end
        idle();
        checks++;
        if (vld_run != 3) begin
            errors++;
            $display("FAIL b2b_valid_run: %0d consecutive valid cycles, want 3", vld_run);
        end
    endtask

    task automatic test_random();
        exp_t e;
        int   op;
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            drive(mk(op < 5 || op == 9, op >= 5, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     32'($urandom_range(0, 4*DEPTH + 7)), $urandom));
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (ReadValid !== e.vld || Error !== e.err || ReadData !== e.dat) begin
                errors++;
                $display("FAIL random[%0d]: vld=%b err=%b dat=%h, want vld=%b err=%b dat=%h",
                         i, ReadValid, Error, ReadData, e.vld, e.err, e.dat);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        int   n;
        drive(mk(0, 1, 2'd2, 0, 32'h8, 32'hCAFEF00D));
        @(posedge clk); #1;
        void'(sb.pop_front());
        drive(mk(1, 0, 2'd2, 0, 32'h8, 0));
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if (ReadValid !== e.vld || ReadData !== e.dat) begin
            errors++;
            $display("FAIL burst_load: vld=%b dat=%h, want vld=%b dat=%h", ReadValid, ReadData, e.vld, e.dat);
        end
        drive(mk(1, 0, 2'd2, 0, 32'h4, 0));
        rst_n = 1'b0;
        #1;
        checks++;
        if (ReadValid !== 1'b0 || Ready !== 1'b0 || Error !== 1'b0 || ReadData !== IDLE_DAT) begin
            errors++;
            $display("FAIL mid_reset: vld=%b rdy=%b err=%b dat=%h, want 0 0 0 %h",
                     ReadValid, Ready, Error, ReadData, IDLE_DAT);
        end
        sb.delete();
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        while (Ready !== 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL reinit_length: ready low for %0d cycles, want %0d", n, DEPTH);
        end
        clear_ref();
        drive(mk(1, 0, 2'd2, 0, 32'h8, 0));
        @(posedge clk); #1; idle();
        e = sb.pop_front(); checks++;
        if (ReadValid !== e.vld || Error !== e.err || ReadData !== e.dat) begin
            errors++;
            $display("FAIL recleared: vld=%b err=%b dat=%h, want vld=%b err=%b dat=%h",
                     ReadValid, Error, ReadData, e.vld, e.err, e.dat);
        end
        @(posedge clk); #1;
        checks++;
        if (ReadValid !== 1'b0 || ReadData !== IDLE_DAT) begin
            errors++;
            $display("FAIL idle_readdata: vld=%b dat=%h, want 0 %h", ReadValid, ReadData, IDLE_DAT);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        Address = 32'h0; WriteData = 32'h0;
        idle();
        clear_ref();
        #1;
        test_reset();
        test_sized_loads();
        test_partial_stores();
        test_faults();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
